// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Data wins over fetch; a redirect during a fetch drops its response; a watchdog aborts
// accesses that never see mem_ready. Define ARB_FAIRNESS_EN to force a fetch grant after
// STARVE_MAX data grants in a row that skipped over a waiting fetch.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          dm_err,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam int unsigned   TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusyD, StBusyI} state_e;

    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          dm_valid_q, dm_valid_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_err_q, dm_err_d;
    logic          discard_q, discard_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          fetch_pend;
    logic          grant_data;
    logic          grant_fetch;

    assign fetch_pend = if_req & ~if_flush;

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          force_fetch;

    assign force_fetch = fetch_pend & (starve_q == SW'(STARVE_MAX));
    assign grant_data  = dm_req & ~force_fetch;

    // Count data grants that overtook a waiting fetch; any fetch grant resets the count.
    always_comb begin
        starve_d = starve_q;
        if (state_q == StIdle) begin
            if (grant_fetch) begin
                starve_d = '0;
            end else if (grant_data && fetch_pend) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Threshold only matters when fairness is built in.
    logic unused_starve_max;
    assign unused_starve_max = ^32'(STARVE_MAX);
    assign grant_data        = dm_req;
`endif

    assign grant_fetch = fetch_pend & ~grant_data;

    // Next-state: grant in IDLE, then wait for mem_ready or the watchdog in BUSY.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rdata_d  = if_rdata_q;
        discard_d   = discard_q;
        tmo_cnt_d   = tmo_cnt_q;
        dm_valid_d  = 1'b0;
        if_valid_d  = 1'b0;
        dm_err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                discard_d = 1'b0;
                tmo_cnt_d = '0;
                if (grant_data) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (grant_fetch) begin
                    state_d     = StBusyI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            StBusyD, StBusyI: begin
                // A redirect never aborts the bus transfer; it only drops the response.
                if (state_q == StBusyI && if_flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    tmo_cnt_d = '0;
                    discard_d = 1'b0;
                    if (state_q == StBusyD) begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = ~(discard_q | if_flush);
                    end
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    tmo_cnt_d = '0;
                    discard_d = 1'b0;
                    dm_err_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, bus and response registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dm_rdata_q  <= '0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_err_q    <= 1'b0;
            discard_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            if_valid_q  <= if_valid_d;
            dm_err_q    <= dm_err_d;
            discard_q   <= discard_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign if_valid  = if_valid_q;
    assign dm_err    = dm_err_q;

    // Freezes drop in the pulse cycle so the pipeline advances exactly then; gated by reset.
    assign stall_m = rst & dm_req & ~dm_valid_q & ~dm_err_q;
    assign stall_f = stall_m | (rst & if_req & ~if_valid_q & ~if_flush);
endmodule
